reversi_accel_hls_deadlock_ctrl: RTL
====================================

Name: reversi_accel_hls_deadlock_ctrl

Overview:
- Central sequencer for the per-process deadlock detect units of the reversi accelerator's HLS dataflow region.
- Collects each unit's local detect flag and arbitrates among simultaneous detectors with round-robin priority.
- Launches a token walk from the granted process, confirms the cycle when the token returns to that process, then latches a sticky deadlock report until acknowledged.
- Sits one level above the PROC_NUM detect units; drives their shared dl_detect_in, per-unit origin and per-unit token_clear inputs.

Parameters:
- PROC_NUM, 4, number of dataflow processes / detect units (2..16).
- ID_W, 2, width of process index; must satisfy 2**ID_W >= PROC_NUM.
- CNT_W, 8, width of hop counter.
- WALK_TIMEOUT, 64, maximum WALK cycles before abort (used only with the optional feature).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dl_detect_vec  in  PROC_NUM  bit i = dl_detect_out of unit i.
- token_return_vec  in  PROC_NUM  bit i = OR of token_in_vec at unit i, this cycle.
- report_ack  in  1  single-cycle acknowledge of a latched report.
- dl_detect_in  out  1  broadcast to all units; high in GRANT, WALK, REPORT.
- origin_vec  out  PROC_NUM  one-hot origin pulse to the granted unit.
- token_clear_vec  out  PROC_NUM  one-hot token kill to the granted unit.
- deadlock  out  1  sticky deadlock-confirmed flag.
- deadlock_proc_id  out  ID_W  index of the process that closed the cycle.
- hop_count  out  CNT_W  token arrival cycles counted during the last walk.
- walk_timeout  out  1  sticky abort flag (optional feature only).

Behaviour:
- Reset: state=IDLE; all outputs 0; last_grant=PROC_NUM-1, so the first grant search starts at process 0; sel=0.
- Four states: IDLE, GRANT, WALK, REPORT. State and all outputs are registered except token_clear_vec.

IDLE:
- dl_detect_in=0.
- If |dl_detect_vec, sel = first set bit searching upward from last_grant+1, wrapping modulo PROC_NUM; next state GRANT.
- Otherwise stay in IDLE.

GRANT (exactly 1 cycle):
- origin_vec = 1<<sel; dl_detect_in=1.
- hop_count cleared to 0; walk timer cleared.
- Next state WALK.

WALK:
- dl_detect_in=1; origin_vec=0.
- Each cycle with |token_return_vec: hop_count += 1, saturating at all-ones.
- If token_return_vec[sel]=1:
  - token_clear_vec = 1<<sel combinationally in that same cycle.
  - Next edge: deadlock=1, deadlock_proc_id=sel, state=REPORT.
- Deassertion of dl_detect_vec during WALK does not abort the walk.

REPORT:
- dl_detect_in=1; deadlock held high.
- On report_ack: deadlock=0, last_grant=sel, state=IDLE. hop_count and deadlock_proc_id keep their values.

Other rules:
- report_ack outside REPORT is ignored.
- token_clear_vec is 0 in every state except WALK at the return cycle.
- A return seen in the GRANT cycle is ignored; the origin token cannot arrive before WALK.
- Reset asserted mid-walk or mid-report returns immediately to the reset values; no token_clear is issued.
- Round-robin fairness: after a completed or aborted walk, the serviced sel has lowest priority on the next grant.

Optional Feature:
- Macro: REVERSI_DL_WALK_TIMEOUT_EN.
- Defined:
  - WALK runs a timer starting at 0.
  - If the timer reaches WALK_TIMEOUT-1 with no return at sel: walk_timeout=1 (sticky until reset), last_grant=sel, state=IDLE, and token_clear_vec=1<<sel for that cycle to flush the token.
  - A return arriving on the same cycle as the timeout wins: the walk goes to REPORT and walk_timeout stays 0.
- Undefined:
  - No timer logic; WALK waits indefinitely.
  - walk_timeout is tied to 0.

Test Plan:
- Reset then dl_detect_vec=4'b0100 -> GRANT next cycle with origin_vec=4'b0100 for 1 cycle and dl_detect_in=1; token_return_vec bits 3,0,2 on three consecutive cycles -> token_clear_vec=4'b0100 on the third; then deadlock=1, deadlock_proc_id=2, hop_count=3.
- Simultaneous dl_detect_vec=4'b1010 after reset -> sel=1; after report_ack, still 4'b1010 -> sel=3; next round -> sel=1.
- In REPORT, pulse report_ack -> deadlock=0 and dl_detect_in=0 the next cycle; report_ack pulsed while in IDLE -> no state change.
- Assert reset during WALK after 2 hops -> all outputs 0 immediately; first grant after release with dl_detect_vec=4'b1111 -> sel=0.
- With REVERSI_DL_WALK_TIMEOUT_EN and WALK_TIMEOUT=8, no return at sel -> after 8 WALK cycles walk_timeout=1, token_clear_vec pulse at sel, state IDLE, deadlock=0.
- With REVERSI_DL_WALK_TIMEOUT_EN, 300 non-origin token_return_vec cycles with CNT_W=8 -> hop_count saturates at 255 (WALK_TIMEOUT=512); without the macro -> walk_timeout stays 0.

Source files
------------

// File: rtl/reversi_accel_hls_deadlock_ctrl.sv
// reversi_accel_hls_deadlock_ctrl
// Central sequencer for the per-process deadlock detect units of the reversi
// accelerator's HLS dataflow region. It picks one detecting unit round-robin,
// launches a token walk from it and confirms a deadlock when the token comes
// back. It then holds a sticky report until report_ack arrives.
//
// Optional feature: define REVERSI_DL_WALK_TIMEOUT_EN to abort walks that run
// WALK_TIMEOUT cycles without the token returning (sticky walk_timeout flag).
// Without it, walk_timeout is tied low and a walk waits indefinitely.
//
// state  | meaning
// IDLE   | no walk in progress; watching dl_detect_vec for detectors
// GRANT  | one-cycle origin pulse to the granted unit; counters cleared
// WALK   | token circulating; waiting for it to return to the granted unit
// REPORT | deadlock confirmed; report held until report_ack

module reversi_accel_hls_deadlock_ctrl #(
    parameter int PROC_NUM     = 4,
    parameter int ID_W         = 2,
    parameter int CNT_W        = 8,
    parameter int WALK_TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] token_return_vec,
    input  logic                report_ack,
    output logic                dl_detect_in,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic [PROC_NUM-1:0] token_clear_vec,
    output logic                deadlock,
    output logic [ID_W-1:0]     deadlock_proc_id,
    output logic [CNT_W-1:0]    hop_count,
    output logic                walk_timeout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_WALK   = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    localparam logic [ID_W:0]       PROC_NUM_W = (ID_W+1)'(PROC_NUM);
    localparam logic [ID_W:0]       ID_ONE     = (ID_W+1)'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [PROC_NUM-1:0] ONE_HOT_0  = {{(PROC_NUM-1){1'b0}}, 1'b1};

    // Elaboration-time guard against parameter sets the index width cannot cover.
    if (((2**ID_W) < PROC_NUM) || (PROC_NUM < 2) || (WALK_TIMEOUT < 1)) begin : g_param_check
        $error("reversi_accel_hls_deadlock_ctrl: illegal parameter combination");
    end

    state_t              state_q, state_d;
    logic [ID_W-1:0]     sel_q, sel_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [PROC_NUM-1:0] origin_d;
    logic                deadlock_d;
    logic [ID_W-1:0]     proc_id_d;
    logic [CNT_W-1:0]    hop_d;

    logic [ID_W:0]       rr_start;
    logic [ID_W:0]       rr_off;
    logic [ID_W:0]       rr_sum;
    logic [PROC_NUM-1:0] rr_rot;
    logic [ID_W-1:0]     rr_pick;

`ifdef REVERSI_DL_WALK_TIMEOUT_EN
    // Down-counter loaded on grant; terminal count 0 marks the last WALK cycle.
    localparam int              TMR_W    = (WALK_TIMEOUT > 1) ? $clog2(WALK_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WALK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             tmo_q, tmo_d;
`endif

    // Round-robin pick: rotate the request vector so last_grant+1 lands at bit 0,
    // take the lowest set bit, then map the offset back to a process index.
    always_comb begin
        rr_start = {1'b0, last_grant_q} + ID_ONE;
        if (rr_start >= PROC_NUM_W) begin
            rr_start = '0;
        end
        rr_rot = PROC_NUM'({dl_detect_vec, dl_detect_vec} >> rr_start);
        rr_off = '0;
        for (int j = PROC_NUM - 1; j >= 0; j--) begin
            if (rr_rot[j]) begin
                rr_off = (ID_W+1)'(j);
            end
        end
        rr_sum = rr_start + rr_off;
        if (rr_sum >= PROC_NUM_W) begin
            rr_sum = rr_sum - PROC_NUM_W;
        end
        rr_pick = ID_W'(rr_sum);
    end

    // Next-state and next-output logic; token_clear_vec is the only combinational output.
    always_comb begin
        state_d         = state_q;
        sel_d           = sel_q;
        last_grant_d    = last_grant_q;
        origin_d        = '0;
        deadlock_d      = deadlock;
        proc_id_d       = deadlock_proc_id;
        hop_d           = hop_count;
        token_clear_vec = '0;
`ifdef REVERSI_DL_WALK_TIMEOUT_EN
        tmr_d           = tmr_q;
        tmo_d           = tmo_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (|dl_detect_vec) begin
                    sel_d    = rr_pick;
                    origin_d = ONE_HOT_0 << rr_pick;
                    hop_d    = '0;
`ifdef REVERSI_DL_WALK_TIMEOUT_EN
                    tmr_d    = TMR_LOAD;
`endif
                    state_d  = S_GRANT;
                end
            end

            S_GRANT: begin
                // Returns seen here are ignored: the origin token is not out yet.
                hop_d   = '0;
`ifdef REVERSI_DL_WALK_TIMEOUT_EN
                tmr_d   = TMR_LOAD;
`endif
                state_d = S_WALK;
            end

            S_WALK: begin
                if ((|token_return_vec) && (hop_count != '1)) begin
                    hop_d = hop_count + CNT_ONE;
                end
                if (token_return_vec[sel_q]) begin
                    token_clear_vec = ONE_HOT_0 << sel_q;
                    deadlock_d      = 1'b1;
                    proc_id_d       = sel_q;
                    state_d         = S_REPORT;
                end
`ifdef REVERSI_DL_WALK_TIMEOUT_EN
                else if (tmr_q == '0) begin
                    // Flush the stray token and give up on this walk.
                    token_clear_vec = ONE_HOT_0 << sel_q;
                    tmo_d           = 1'b1;
                    last_grant_d    = sel_q;
                    state_d         = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
`endif
            end

            S_REPORT: begin
                if (report_ack) begin
                    deadlock_d   = 1'b0;
                    last_grant_d = sel_q;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; dl_detect_in follows the next state so it is high in GRANT/WALK/REPORT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            sel_q            <= '0;
            last_grant_q     <= ID_W'(PROC_NUM - 1);
            dl_detect_in     <= 1'b0;
            origin_vec       <= '0;
            deadlock         <= 1'b0;
            deadlock_proc_id <= '0;
            hop_count        <= '0;
        end else begin
            state_q          <= state_d;
            sel_q            <= sel_d;
            last_grant_q     <= last_grant_d;
            dl_detect_in     <= (state_d != S_IDLE);
            origin_vec       <= origin_d;
            deadlock         <= deadlock_d;
            deadlock_proc_id <= proc_id_d;
            hop_count        <= hop_d;
        end
    end

`ifdef REVERSI_DL_WALK_TIMEOUT_EN
    // Walk timer and sticky abort flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmr_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            tmo_q <= tmo_d;
        end
    end

    assign walk_timeout = tmo_q;
`else
    assign walk_timeout = 1'b0;
`endif

endmodule
